stream_load: RTL and testbench
==============================

Name: stream_load

Overview:
Byte-stream image receiver. It writes an incoming raster into the input SRAM bank and is the inbound counterpart of the save block, which streams the filtered image out of SRAM. It parses a 4-byte dimension header, writes M*N pixels row-major from address 0, and reports loadF, M, N and dataCount to the top-level sequencer. It replaces file-based loading and drives the same sram/mux21 address and write path.

Parameters:
DATA_WIDTH, 8, pixel and stream byte width
ADDR_WIDTH, 18, SRAM address width
DEPTH, 262144, SRAM capacity in pixels; the largest legal M*N

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  load enable from sequencer; level-held for the whole load
s_data  in  DATA_WIDTH  stream byte
s_valid  in  1  stream byte valid
s_ready  out  1  block accepts byte; transfer occurs on s_valid & s_ready at posedge
addr  out  ADDR_WIDTH  SRAM write address
data  out  DATA_WIDTH  SRAM write data
wr  out  1  SRAM write strobe, active-high
M  out  16  image rows
N  out  16  image columns
dataCount  out  32  pixels written (equals M*N on success)
loadF  out  1  load finished; level
err  out  1  header rejected (M*N > DEPTH); level

Behaviour:
- Reset (asynchronous): state=IDLE; s_ready, wr, loadF, err = 0; addr, data, M, N, dataCount = 0.
- States: IDLE, HDR, CHK, PIX, DONE.
- IDLE: s_ready=0. On en=1, clear dataCount, err and header byte index, then go to HDR.
- HDR: s_ready=1. Accepts 4 bytes, big-endian: M[15:8], M[7:0], N[15:8], N[7:0]. After the 4th byte, go to CHK.
- CHK (one cycle): s_ready=0. Compute the 32-bit product P=M*N in a register.
  - P==0: go to DONE with dataCount=0.
  - P>DEPTH: set err=1 and go to DONE.
  - Otherwise go to PIX.
- PIX: s_ready=1. On each handshake, at the next edge: addr<=dataCount[ADDR_WIDTH-1:0], data<=s_data, wr<=1, dataCount<=dataCount+1.
  - wr is 1 only in cycles following a handshake. One-cycle write latency.
  - s_valid gaps are allowed, with no SRAM write on gap cycles.
  - When the handshake brings dataCount to P, go to DONE. s_ready is 0 in the cycle after the last byte.
- DONE: s_ready=0, loadF=1. M, N, dataCount and err hold. The final wr pulse for the last pixel coincides with the first DONE cycle; loadF rises in that same cycle.
- en=0 while in DONE: go to IDLE and clear loadF. M, N and dataCount keep their values for downstream amf/save.
- en=0 in HDR, CHK or PIX: abort to IDLE. loadF=0, wr=0 next cycle, dataCount holds a partial value. A later en=1 restarts with a new header.
- Bytes presented while s_ready=0 are neither consumed nor written.
- dataCount never wraps. The P<=DEPTH check guarantees addr stays below DEPTH.
- Reset mid-operation: immediate return to reset values. SRAM contents are not cleared.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH and DEPTH defaults, plus the state encoding constants (IDLE=0 to DONE=4, 3-bit).
- No sub-module is required. The header parser can optionally be a separate hdr_parse sub-module: 4-byte shift with index counter, outputs M, N and hdr_done.

Test Plan:
- Stream header 00 04 00 03 then 12 bytes 0x01..0x0C with continuous valid -> M=4, N=3, 12 wr pulses at addr 0..11 with data 01..0C, dataCount=12, loadF=1, err=0.
- Same image with s_valid toggled 1/0 and 3-cycle gaps -> identical SRAM contents, no wr on gap cycles, loadF=1 after the 12th byte.
- Header 00 00 00 05 -> P=0, DONE two cycles after the 4th byte, dataCount=0, loadF=1, no wr.
- Header 02 58 02 58 (600x600=360000) -> err=1, loadF=1, s_ready=0 afterwards, no wr.
- Header 01 00 04 00 (262144) then full stream -> last write at addr 0x3FFFF, dataCount=262144, err=0.
- Assert rst asynchronously, and separately drop en, after 5 of 12 pixels -> all outputs at reset values, or IDLE with loadF=0 and wr=0. A re-run of scenario 1 then completes correctly.

Source files
------------

// File: rtl/stream_load_pkg.sv
// Shared constants and state encoding for the stream_load image receiver.
//   DefDataWidth / DefAddrWidth / DefDepth : default parameter values
//   state_e                                : receiver FSM encoding (IDLE=0 .. DONE=4)
package stream_load_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefAddrWidth = 18;
  localparam int unsigned DefDepth     = 262144;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StHdr  = 3'd1,
    StChk  = 3'd2,
    StPix  = 3'd3,
    StDone = 3'd4
  } state_e;

endpackage

// File: rtl/stream_load.sv
// Byte-stream image receiver. Parses a 4-byte big-endian header (M, N), then writes
// M*N pixels row-major into the input SRAM starting at address 0.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   en               : load enable, held high for the whole load
//   s_data/s_valid   : inbound stream byte and valid
//   s_ready          : stream accept; transfer on s_valid & s_ready at posedge
//   addr/data/wr     : SRAM write port (registered, one-cycle latency)
//   M, N             : image rows / columns from the header
//   dataCount        : pixels written so far
//   loadF            : load finished (level, high while in DONE)
//   err              : header rejected because M*N exceeds DEPTH
module stream_load
  import stream_load_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = DefDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  wr,
  output logic [15:0]           M,
  output logic [15:0]           N,
  output logic [31:0]           dataCount,
  output logic                  loadF,
  output logic                  err
);

  localparam logic [31:0] DepthW = 32'(DEPTH);

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [15:0]           m_q, m_d, n_q, n_d;
  logic [31:0]           prod_q, prod_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;

  logic        hs;
  logic [31:0] prod_c;
  logic [31:0] cnt_inc;

  // Gated by en so a byte is never consumed in the cycle an abort is taking effect.
  assign s_ready = en && ((state_q == StHdr) || (state_q == StPix));
  assign hs      = s_valid && s_ready;
  assign prod_c  = 32'(m_q) * 32'(n_q);
  assign cnt_inc = cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    m_d     = m_q;
    n_d     = n_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          cnt_d   = '0;
          err_d   = 1'b0;
          idx_d   = '0;
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (!en) begin
          state_d = StIdle;
        end else if (hs) begin
          idx_d = idx_q + 2'd1;
          unique case (idx_q)
            2'd0: m_d[15:8] = s_data[7:0];
            2'd1: m_d[7:0]  = s_data[7:0];
            2'd2: n_d[15:8] = s_data[7:0];
            2'd3: n_d[7:0]  = s_data[7:0];
            default: ;
          endcase
          if (idx_q == 2'd3) state_d = StChk;
        end
      end
      StChk: begin
        if (!en) begin
          state_d = StIdle;
        end else begin
          prod_d = prod_c;
          if (prod_c == 32'd0) begin
            state_d = StDone;
          end else if (prod_c > DepthW) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StPix;
          end
        end
      end
      StPix: begin
        if (!en) begin
          state_d = StIdle;
        end else if (hs) begin
          addr_d = cnt_q[ADDR_WIDTH-1:0];
          data_d = s_data;
          wr_d   = 1'b1;
          cnt_d  = cnt_inc;
          if (cnt_inc == prod_q) state_d = StDone;
        end
      end
      StDone: begin
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      m_q     <= '0;
      n_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      n_q     <= n_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  assign addr      = addr_q;
  assign data      = data_q;
  assign wr        = wr_q;
  assign M         = m_q;
  assign N         = n_q;
  assign dataCount = cnt_q;
  assign err       = err_q;
  // The last pixel's write pulse and loadF both appear in the first DONE cycle.
  assign loadF     = (state_q == StDone);

endmodule

// File: tb/tb_stream_load.sv
// Directed self-checking bench for stream_load. DEPTH is scaled to 1024 (10-bit address)
// so the full-capacity image stays short; the boundary cases are the same in kind.
module tb_stream_load;

  localparam int unsigned TbDepth = 1024;
  localparam int unsigned TbAw    = 10;

  logic            clk, rst, en, s_valid, s_ready, wr, loadF, err;
  logic [7:0]      s_data, data;
  logic [TbAw-1:0] addr;
  logic [15:0]     M, N;
  logic [31:0]     dataCount;

  int checks = 0;
  int errors = 0;

  stream_load #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(TbAw),
    .DEPTH     (TbDepth)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .addr     (addr),
    .data     (data),
    .wr       (wr),
    .M        (M),
    .N        (N),
    .dataCount(dataCount),
    .loadF    (loadF),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM write monitor.
  logic [7:0]  mem [0:TbDepth-1];
  int          wr_cnt;
  int          wr_at_loadf;
  logic [31:0] last_addr;

  always @(negedge clk) begin
    if (wr) begin
      mem[addr] = data;
      wr_cnt++;
      last_addr = 32'(addr);
      if (loadF) wr_at_loadf++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt      = 0;
    wr_at_loadf = 0;
    last_addr   = '0;
    for (int i = 0; i < int'(TbDepth); i++) mem[i] = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n       = 0;
    s_data  = b;
    s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    else begin
      @(posedge clk);
      tick();
    end
  endtask

  task automatic start();
    en      = 1'b0;
    s_valid = 1'b0;
    tick();
    clear_mon();
    en = 1'b1;
  endtask

  task automatic header(input logic [15:0] m, input logic [15:0] n);
    send_byte(m[15:8]);
    send_byte(m[7:0]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    s_valid = 1'b0;
  endtask

  task automatic pixels(input int cnt, input bit gappy);
    for (int i = 0; i < cnt; i++) begin
      send_byte(8'(i + 1));
      if (gappy) begin
        s_valid = 1'b0;
        repeat ((i % 2 == 0) ? 1 : 3) tick();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic check_image(input string tag, input int cnt);
    int bad;
    bad = 0;
    for (int i = 0; i < cnt; i++) if (mem[i] !== 8'(i + 1)) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  task automatic run_basic(input string tag, input bit gappy);
    start();
    header(16'd4, 16'd3);
    pixels(12, gappy);
    check({tag, "_loadF"}, 32'(loadF), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_sready_done"}, 32'(s_ready), 32'd0);
    check({tag, "_M"}, 32'(M), 32'd4);
    check({tag, "_N"}, 32'(N), 32'd3);
    check({tag, "_count"}, dataCount, 32'd12);
    check({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd12);
    check({tag, "_last_wr_with_loadF"}, 32'(wr_at_loadf), 32'd1);
    check({tag, "_last_addr"}, last_addr, 32'd11);
    check_image({tag, "_image"}, 12);
    tick();
    check({tag, "_wr_after"}, 32'(wr), 32'd0);
    check({tag, "_loadF_hold"}, 32'(loadF), 32'd1);
    en = 1'b0;
    tick();
    check({tag, "_loadF_clear"}, 32'(loadF), 32'd0);
    check({tag, "_M_keep"}, 32'(M), 32'd4);
    check({tag, "_count_keep"}, dataCount, 32'd12);
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    clear_mon();
    #1 rst = 1'b1;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_wr", 32'(wr), 32'd0);
    check("rst_loadF", 32'(loadF), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_M", 32'(M), 32'd0);
    check("rst_N", 32'(N), 32'd0);
    check("rst_count", dataCount, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("idle_s_ready", 32'(s_ready), 32'd0);

    // 4x3 image, continuous valid, then with gaps.
    run_basic("s1", 1'b0);
    run_basic("s2_gaps", 1'b1);

    // Zero-size image: CHK then DONE, no writes.
    start();
    header(16'd0, 16'd5);
    check("p0_chk_sready", 32'(s_ready), 32'd0);
    check("p0_chk_loadF", 32'(loadF), 32'd0);
    tick();
    check("p0_loadF", 32'(loadF), 32'd1);
    check("p0_count", dataCount, 32'd0);
    check("p0_err", 32'(err), 32'd0);
    check("p0_N", 32'(N), 32'd5);
    s_data  = 8'hAA;
    s_valid = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    check("p0_wr_cnt", 32'(wr_cnt), 32'd0);

    // Oversize header 600x600.
    start();
    header(16'd600, 16'd600);
    tick();
    check("big_err", 32'(err), 32'd1);
    check("big_loadF", 32'(loadF), 32'd1);
    check("big_M", 32'(M), 32'd600);
    s_valid = 1'b1;
    tick();
    check("big_sready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    check("big_wr_cnt", 32'(wr_cnt), 32'd0);

    // DEPTH+1 = 5*205 is rejected.
    start();
    header(16'd5, 16'd205);
    check("err_cleared_on_start", 32'(err), 32'd0);
    tick();
    check("over1_err", 32'(err), 32'd1);
    check("over1_loadF", 32'(loadF), 32'd1);

    // Exactly DEPTH = 32x32 fills the whole address space.
    start();
    header(16'd32, 16'd32);
    pixels(int'(TbDepth), 1'b0);
    check("full_err", 32'(err), 32'd0);
    check("full_loadF", 32'(loadF), 32'd1);
    check("full_count", dataCount, 32'(TbDepth));
    check("full_wr_cnt", 32'(wr_cnt), 32'(TbDepth));
    check("full_last_addr", last_addr, 32'h3FF);
    check_image("full_image", int'(TbDepth));

    // Asynchronous reset after 5 of 12 pixels.
    start();
    header(16'd4, 16'd3);
    pixels(5, 1'b0);
    check("pre_rst_wr", 32'(wr), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_wr", 32'(wr), 32'd0);
    check("mid_rst_addr", 32'(addr), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_count", dataCount, 32'd0);
    check("mid_rst_M", 32'(M), 32'd0);
    check("mid_rst_sready", 32'(s_ready), 32'd0);
    tick();
    rst = 1'b0;
    run_basic("after_rst", 1'b0);

    // en dropped after 5 of 12 pixels.
    start();
    header(16'd4, 16'd3);
    pixels(5, 1'b0);
    en = 1'b0;
    tick();
    check("abort_loadF", 32'(loadF), 32'd0);
    check("abort_wr", 32'(wr), 32'd0);
    check("abort_sready", 32'(s_ready), 32'd0);
    check("abort_count", dataCount, 32'd5);
    run_basic("after_abort", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
